pad_ctrl: RTL and testbench

Register-programmable controller that sits inside the core directly upstream of the padring. It owns the per-pad control signals the padring consumes: output data, output enable (bar), input enable and the 8-bit pad configuration. It also synchronises the data returned from the pads and raises edge-triggered interrupts. Software reaches it over a simple valid/ready request/response register port.

---
 rtl/pad_ctrl_pkg.sv | 30 +++
 rtl/pad_ctrl_pin.sv | 84 ++++++++
 rtl/pad_ctrl.sv | 94 +++++++++
 tb/tb_pad_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared constants for the pad controller: geometry, control-word layout and addresses.
package pad_ctrl_pkg;

    localparam int unsigned NPINS     = 36;
    localparam int unsigned CFGW      = 8;
    localparam int unsigned DW        = 32;
    localparam int unsigned AW        = 8;
    localparam int unsigned SIDE_PINS = 9;
    localparam int unsigned PIN_IW    = $clog2(NPINS);

    // Pad index = side * SIDE_PINS + bit
    localparam int unsigned WE = 0;
    localparam int unsigned NO = 1;
    localparam int unsigned SO = 2;
    localparam int unsigned EA = 3;

    localparam int unsigned DOUT    = 0;
    localparam int unsigned OEN     = 1;
    localparam int unsigned IE      = 2;
    localparam int unsigned CFG_LSB = 8;
    localparam int unsigned CFG_MSB = 15;
    localparam int unsigned IRQ_EN  = 16;
    localparam int unsigned POL     = 17;
    localparam int unsigned IN      = 24;
    localparam int unsigned PEND    = 25;

    localparam logic [AW-1:0] ADDR_PEND_LO = AW'(NPINS);
    localparam logic [AW-1:0] ADDR_PEND_HI = AW'(NPINS + 1);

endpackage

// File: rtl/pad_ctrl_pin.sv
// One pad: control fields, input synchroniser, receiver settle counter and edge-triggered pending bit.
module pad_ctrl_pin
    import pad_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic            w1c,
    input  logic [DW-1:0]   wdata,
    input  logic            din,
    output logic            dout,
    output logic            oen,
    output logic            ie,
    output logic [CFGW-1:0] cfg,
    output logic            irq_en,
    output logic            pending,
    output logic [DW-1:0]   rdata_c
);

    logic       sync_q;
    logic       in_q;
    logic       prev_q;
    logic       pol_q;
    logic [1:0] settle_q;
    logic       edge_hit;
    logic       unused_wdata;

    assign unused_wdata = ^{wdata[DW-1:POL+1], wdata[CFG_LSB-1:IE+1]};

    // Edges only count once the receiver has been enabled for three cycles
    assign edge_hit = (settle_q == 2'd3) && (pol_q ? (~in_q & prev_q) : (in_q & ~prev_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 1'b0;
            in_q     <= 1'b0;
            prev_q   <= 1'b0;
            settle_q <= 2'd0;
            dout     <= 1'b0;
            oen      <= 1'b1;
            ie       <= 1'b0;
            cfg      <= '0;
            irq_en   <= 1'b0;
            pol_q    <= 1'b0;
            pending  <= 1'b0;
        end else begin
            sync_q <= din;
            in_q   <= sync_q;
            prev_q <= in_q;
            if (!ie) begin
                settle_q <= 2'd0;
            end else if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            if (we) begin
                dout   <= wdata[DOUT];
                oen    <= wdata[OEN];
                ie     <= wdata[IE];
                cfg    <= wdata[CFG_MSB:CFG_LSB];
                irq_en <= wdata[IRQ_EN];
                pol_q  <= wdata[POL];
            end
            // A new edge beats a simultaneous clear
            if (edge_hit) begin
                pending <= 1'b1;
            end else if (w1c) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_c                   = '0;
        rdata_c[DOUT]             = dout;
        rdata_c[OEN]              = oen;
        rdata_c[IE]               = ie;
        rdata_c[CFG_MSB:CFG_LSB]  = cfg;
        rdata_c[IRQ_EN]           = irq_en;
        rdata_c[POL]              = pol_q;
        rdata_c[IN]               = in_q;
        rdata_c[PEND]             = pending;
    end

endmodule

// File: rtl/pad_ctrl.sv
// Pad controller top: register port decode, single-outstanding response register and irq reduction.
module pad_ctrl
    import pad_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [AW-1:0]          req_addr,
    input  logic [DW-1:0]          req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DW-1:0]          rsp_rdata,
    output logic                   rsp_err,
    input  logic [NPINS-1:0]       pad_din,
    output logic [NPINS-1:0]       pad_dout,
    output logic [NPINS-1:0]       pad_oen,
    output logic [NPINS-1:0]       pad_ie,
    output logic [NPINS*CFGW-1:0]  pad_cfg,
    output logic                   irq
);

    logic             accept;
    logic [NPINS-1:0] pending;
    logic [NPINS-1:0] irq_en;
    logic [DW-1:0]    pin_rdata [NPINS];
    logic [DW-1:0]    rd_word;
    logic             rd_err;

    assign req_ready = ~rsp_valid;
    assign accept    = req_valid & ~rsp_valid;

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        logic sel;
        assign sel = accept && req_write && (req_addr == AW'(i));

        pad_ctrl_pin u_pin (
            .clk     (clk),
            .rst     (rst),
            .we      (sel),
            .w1c     (sel & req_wdata[PEND]),
            .wdata   (req_wdata),
            .din     (pad_din[i]),
            .dout    (pad_dout[i]),
            .oen     (pad_oen[i]),
            .ie      (pad_ie[i]),
            .cfg     (pad_cfg[i*CFGW +: CFGW]),
            .irq_en  (irq_en[i]),
            .pending (pending[i]),
            .rdata_c (pin_rdata[i])
        );
    end

    // Read data and error flag for the request currently on the port
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (req_addr < ADDR_PEND_LO) begin
            rd_word = pin_rdata[req_addr[PIN_IW-1:0]];
        end else if (req_addr == ADDR_PEND_LO) begin
            rd_word = pending[DW-1:0];
            rd_err  = req_write;
        end else if (req_addr == ADDR_PEND_HI) begin
            rd_word = DW'(pending[NPINS-1:DW]);
            rd_err  = req_write;
        end else begin
            rd_err  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= req_write ? '0 : rd_word;
            rsp_err   <= rd_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pending & irq_en);
        end
    end

endmodule

// File: tb/tb_pad_ctrl.sv
// Self-checking bench for pad_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pad_ctrl;

    localparam int NP = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [7:0]    req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [NP-1:0] pad_din;
    logic [NP-1:0] pad_dout;
    logic [NP-1:0] pad_oen;
    logic [NP-1:0] pad_ie;
    logic [NP*8-1:0] pad_cfg;
    logic          irq;

    int errors = 0;
    int checks = 0;
    logic chk_on = 1'b0;

    pad_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .pad_din   (pad_din),
        .pad_dout  (pad_dout),
        .pad_oen   (pad_oen),
        .pad_ie    (pad_ie),
        .pad_cfg   (pad_cfg),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: per-pin field arrays, din sample history and "cycles enabled" age
    logic [NP-1:0] m_dout, m_oen, m_ie, m_irqen, m_pol, m_pend;
    logic [NP-1:0] m_s1, m_in, m_prev, m_hit, m_clr;
    logic [7:0]    m_cfg [NP];
    int            m_age [NP];
    logic          m_irq, m_rsp_valid, m_err, m_bad;
    logic [31:0]   m_rdata, m_word;
    int            m_a;

    function automatic logic [31:0] pin_word(input int i);
        return 32'(m_dout[i]) + (32'(m_oen[i]) << 1) + (32'(m_ie[i]) << 2)
             + (32'(m_cfg[i]) << 8) + (32'(m_irqen[i]) << 16) + (32'(m_pol[i]) << 17)
             + (32'(m_in[i]) << 24) + (32'(m_pend[i]) << 25);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_dout = '0; m_oen = '1; m_ie = '0; m_irqen = '0; m_pol = '0; m_pend = '0;
            m_s1 = '0; m_in = '0; m_prev = '0;
            for (int i = 0; i < NP; i++) begin
                m_cfg[i] = 8'h00;
                m_age[i] = 0;
            end
            m_irq = 1'b0; m_rsp_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
        end else begin
            m_hit = '0;
            m_clr = '0;
            for (int i = 0; i < NP; i++) begin
                if (m_age[i] >= 3)
                    m_hit[i] = m_pol[i] ? (!m_in[i] && m_prev[i]) : (m_in[i] && !m_prev[i]);
                m_age[i] = m_ie[i] ? ((m_age[i] >= 3) ? 3 : m_age[i] + 1) : 0;
            end
            m_irq = |(m_pend & m_irqen);
            if (req_valid && !m_rsp_valid) begin
                m_a = int'(req_addr);
                m_word = '0;
                m_bad = 1'b0;
                if (m_a < NP) m_word = pin_word(m_a);
                else if (m_a == NP) m_word = m_pend[31:0];
                else if (m_a == NP + 1) m_word = 32'(m_pend[NP-1:32]);
                else m_bad = 1'b1;
                if (req_write && (m_a == NP || m_a == NP + 1)) m_bad = 1'b1;
                m_rsp_valid = 1'b1;
                m_rdata = req_write ? 32'h0 : m_word;
                m_err = m_bad;
                if (req_write && m_a < NP) begin
                    m_dout[m_a]  = req_wdata[0];
                    m_oen[m_a]   = req_wdata[1];
                    m_ie[m_a]    = req_wdata[2];
                    m_cfg[m_a]   = req_wdata[15:8];
                    m_irqen[m_a] = req_wdata[16];
                    m_pol[m_a]   = req_wdata[17];
                    m_clr[m_a]   = req_wdata[25];
                end
            end else if (rsp_ready) begin
                m_rsp_valid = 1'b0;
            end
            m_pend = m_hit | (m_pend & ~m_clr);
            m_prev = m_in;
            m_in   = m_s1;
            m_s1   = pad_din;
        end
    end

    logic [NP*8-1:0] m_cfg_v;
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < NP; i++) m_cfg_v[i*8 +: 8] = m_cfg[i];
            check_eq("m_dout", 288'(pad_dout), 288'(m_dout));
            check_eq("m_oen", 288'(pad_oen), 288'(m_oen));
            check_eq("m_ie", 288'(pad_ie), 288'(m_ie));
            check_eq("m_cfg", 288'(pad_cfg), 288'(m_cfg_v));
            check_eq("m_irq", 288'(irq), 288'(m_irq));
            check_eq("m_rsp_valid", 288'(rsp_valid), 288'(m_rsp_valid));
            check_eq("m_req_ready", 288'(req_ready), 288'(!m_rsp_valid));
            check_eq("m_rdata", 288'(rsp_rdata), 288'(m_rdata));
            check_eq("m_err", 288'(rsp_err), 288'(m_err));
        end
    end

    // One register transaction with rsp_ready held high; returns the response fields
    task automatic bus(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("bus_ready", 288'(req_ready), 288'(1));
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq("bus_rsp_valid", 288'(rsp_valid), 288'(1));
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    logic [31:0] rd;
    logic        er;
    int          pin;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; pad_din = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check_eq("rst_oen", 288'(pad_oen), 288'(36'hF_FFFF_FFFF));
        check_eq("rst_dout", 288'(pad_dout), 288'(0));
        check_eq("rst_ie", 288'(pad_ie), 288'(0));
        check_eq("rst_cfg", 288'(pad_cfg), 288'(0));
        check_eq("rst_irq", 288'(irq), 288'(0));
        check_eq("rst_req_ready", 288'(req_ready), 288'(1));
        rst = 1'b0;
        bus(1'b0, 8'd5, 32'h0, rd, er);
        check_eq("rst_read5", 288'(rd), 288'(32'h0000_0002));

        // Output control fields
        bus(1'b1, 8'd9, 32'h0000_A501, rd, er);
        check_eq("w9_dout", 288'(pad_dout[9]), 288'(1));
        check_eq("w9_oen", 288'(pad_oen[9]), 288'(0));
        check_eq("w9_cfg", 288'(pad_cfg[79:72]), 288'(8'hA5));
        check_eq("w9_rdata", 288'(rd), 288'(0));
        bus(1'b0, 8'd9, 32'h0, rd, er);
        check_eq("r9", 288'(rd), 288'(32'h0000_A501));

        // Rising edge on pin 3 to irq latency, then W1C
        bus(1'b1, 8'd3, 32'h0001_0004, rd, er);
        repeat (4) @(negedge clk);
        pad_din[3] = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("irq_early", 288'(irq), 288'(0));
        @(negedge clk);
        check_eq("irq_rise", 288'(irq), 288'(1));
        bus(1'b0, 8'd36, 32'h0, rd, er);
        check_eq("pend_lo", 288'(rd), 288'(32'h8));
        bus(1'b1, 8'd3, 32'h0201_0004, rd, er);
        @(negedge clk);
        check_eq("irq_fall", 288'(irq), 288'(0));
        bus(1'b0, 8'd3, 32'h0, rd, er);
        check_eq("r3_cleared", 288'(rd), 288'(32'h0101_0004));

        // Enabling the receiver on a high pad must not set pending; falling edge does
        pad_din[35] = 1'b1;
        repeat (3) @(negedge clk);
        bus(1'b1, 8'd35, 32'h0000_0004, rd, er);
        repeat (6) @(negedge clk);
        bus(1'b0, 8'd37, 32'h0, rd, er);
        check_eq("pend_hi_enable", 288'(rd), 288'(0));
        bus(1'b1, 8'd35, 32'h0002_0004, rd, er);
        pad_din[35] = 1'b0;
        repeat (5) @(negedge clk);
        bus(1'b0, 8'd37, 32'h0, rd, er);
        check_eq("pend_hi_fall", 288'(rd), 288'(32'h8));

        // W1C coinciding with a qualifying edge on pin 3
        pad_din[3] = 1'b0;
        repeat (5) @(negedge clk);
        pad_din[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        bus(1'b1, 8'd3, 32'h0201_0004, rd, er);
        bus(1'b0, 8'd36, 32'h0, rd, er);
        check_eq("w1c_vs_set", 288'(rd), 288'(32'h8));

        // Writes to read-only words
        bus(1'b1, 8'd36, 32'hFFFF_FFFF, rd, er);
        check_eq("ro_write_err", 288'(er), 288'(1));
        bus(1'b0, 8'd36, 32'h0, rd, er);
        check_eq("ro_unchanged", 288'(rd), 288'(32'h8));

        // Out-of-range read held under backpressure, then reset mid-response
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h30;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("hold_valid", 288'(rsp_valid), 288'(1));
            check_eq("hold_err", 288'(rsp_err), 288'(1));
            check_eq("hold_rdata", 288'(rsp_rdata), 288'(0));
            check_eq("hold_ready", 288'(req_ready), 288'(0));
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_drop_valid", 288'(rsp_valid), 288'(0));
        check_eq("rst_drop_oen", 288'(pad_oen), 288'(36'hF_FFFF_FFFF));
        check_eq("rst_drop_irq", 288'(irq), 288'(0));
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Random traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req_valid = ($urandom % 3) == 0;
            req_write = $urandom % 2;
            req_addr  = (($urandom % 8) == 0) ? 8'($urandom_range(36, 255)) : 8'($urandom_range(0, 35));
            req_wdata = $urandom;
            rsp_ready = ($urandom % 4) != 0;
            if (($urandom % 3) == 0) begin
                pin = int'($urandom % NP);
                pad_din[pin] = ~pad_din[pin];
            end
            rst = ($urandom % 700) == 0;
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
